ram_sp_arb_192x128: RTL and testbench
=====================================

# ram_sp_arb_192x128

Round-robin arbiter and sequencer that shares one 192x128 single-port bit-write-enable SRAM between one write client and two read clients. Each cycle it grants at most one client, drives the RAM address, write mask, write data and read enable, and steers the RAM's next-cycle read data back to the granted reader. It sits between the 192x128 RAM wrapper and the encoder stages that fill and drain that buffer.

## Interface
- ADR_WD, 8, address width.
- DAT_WD, 128, data width and write-mask width.
- DEPTH, 192, number of valid words; addresses >= DEPTH are illegal.
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- wr_req_i  input  1  write client request.
- wr_adr_i  input  ADR_WD  write address.
- wr_msk_i  input  DAT_WD  per-bit write enable, high active.
- wr_dat_i  input  DAT_WD  write data.
- wr_gnt_o  output  1  write accepted this cycle.
- rd0_req_i / rd1_req_i  input  1  read client 0/1 request.
- rd0_adr_i / rd1_adr_i  input  ADR_WD  read address.
- rd0_gnt_o / rd1_gnt_o  output  1  read accepted this cycle.
- rd0_val_o / rd1_val_o  output  1  read data valid, one cycle after grant.
- rd_dat_o  output  DAT_WD  returned read data, shared by both readers.
- ram_adr_o  output  ADR_WD  RAM address.
- ram_wr_ena_o  output  DAT_WD  RAM write mask, high active.
- ram_wr_dat_o  output  DAT_WD  RAM write data.
- ram_rd_ena_o  output  1  RAM read enable, high active.
- ram_rd_dat_i  input  DAT_WD  RAM read data, valid one cycle after read enable.
- err_o  output  1  sticky illegal-address flag.

## Operation
- Client order: W = 0, R0 = 1, R1 = 2. The 2-bit priority pointer `ptr` names the highest-priority client. It resets to 0.
- Each cycle, the first requesting client scanning from `ptr` cyclically gets the grant. At most one `*_gnt_o` is high.
- After a grant to client k, `ptr` becomes (k+1) mod 3. With no request, `ptr` holds.
- Handshake is valid/ready:
  - A client holds `req`, address, mask and data stable until it sees `gnt`.
  - A grant consumes exactly one access. A request still high in the next cycle is a new access.
  - Dropping `req` before `gnt` is legal and has no effect.
- Grant is combinational from `req` and `ptr`. RAM drive follows the grant in the same cycle:
  - Write grant: `ram_adr_o` = `wr_adr_i`, `ram_wr_ena_o` = `wr_msk_i`, `ram_wr_dat_o` = `wr_dat_i`, `ram_rd_ena_o` = 0.
  - Read grant: `ram_adr_o` = reader address, `ram_wr_ena_o` = 0, `ram_rd_ena_o` = 1.
  - No grant: `ram_wr_ena_o` = 0, `ram_rd_ena_o` = 0, `ram_adr_o` and `ram_wr_dat_o` = 0.
- Read return: a registered tag {valid, reader id, illegal} records each read grant. Next cycle, the tagged reader's `val` pulses for one cycle.
  - `rd_dat_o` = `ram_rd_dat_i`, or 0 if the access was illegal.
  - `rd_dat_o` = 0 when no `val` is high.
- Illegal address (>= DEPTH):
  - The request is still granted, so the client cannot hang.
  - The RAM sees no access: mask 0 and read enable 0.
  - A read still returns `val`, with data 0.
  - `err_o` sets and stays high until reset.
- An all-zero write mask is a legal write. It is granted and changes nothing in the RAM.

## Timing
- Reset values: all `gnt` and `val` 0, `rd_dat_o` 0, all `ram_*` outputs 0, `err_o` 0, `ptr` 0, tag invalid.
- Grant latency is 0 cycles: `gnt` appears in the same cycle as `req` when the client wins.
- Read data latency is 1 cycle from grant.
- Maximum throughput is one access per cycle. A write followed by a read of the same address in the next cycle returns the new data, because the RAM is single-port and sequential.
- Worst-case wait for a continuously requesting client is 2 cycles.
- Reset asserted mid-read: the pending `val` is suppressed. The tag clears on the reset edge, so no `val` appears in the cycle after reset.

## Structure
- Shared package `enc_mem_pkg` holds:
  - client index constants CLI_WR = 0, CLI_RD0 = 1, CLI_RD1 = 2;
  - the read-tag struct {vld, id, ill}.
- One sub-module, `rr_arb3`: a 3-way round-robin picker with `ptr` register, inputs req[2:0], outputs one-hot gnt[2:0].
- Address-range check, RAM mux, tag register and `err_o` live in the top module.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles, `ram_rd_ena_o` = 0.
- Write client alone, adr = 10, msk = all-ones, dat = 0xA5..A5. Then R0 reads adr 10 in the next cycle. Expect `wr_gnt_o` in cycle 0, `rd0_gnt_o` in cycle 1, `rd0_val_o` in cycle 2 with `rd_dat_o` = 0xA5..A5.
- All three requesting continuously from reset. Expect grant order W, R0, R1, W, R0, R1, and `val` alternating R0/R1 one cycle after each read grant.
- Partial mask: write 0x00..FF with msk = 0xFF in the low bits over prior 0xFF..FF contents. Read returns 0xFF..FF, i.e. the high bits are unchanged.
- R1 reads adr 200. Expect `rd1_gnt_o`, `ram_rd_ena_o` = 0, `rd1_val_o` next cycle with data 0, and `err_o` high until reset. A write to adr 192 drives `ram_wr_ena_o` = 0.
- R0 granted, `rst` asserted in the following cycle. Expect no `rd0_val_o` and `ptr` back at W.

Source files
------------

// File: rtl/enc_mem_pkg.sv
// Shared constants and types for the encoder buffer RAM arbiter.
// Client indices, geometry and the read-return tag are defined here.
package enc_mem_pkg;

    localparam int ADR_WD = 8;
    localparam int DAT_WD = 128;
    localparam int DEPTH  = 192;

    localparam logic [1:0] CLI_WR  = 2'd0;
    localparam logic [1:0] CLI_RD0 = 2'd1;
    localparam logic [1:0] CLI_RD1 = 2'd2;

    // id: 0 = reader 0, 1 = reader 1; ill marks an out-of-range access
    typedef struct packed {
        logic vld;
        logic id;
        logic ill;
    } rd_tag_t;

    function automatic logic adr_ill(input logic [ADR_WD-1:0] adr);
        return adr >= ADR_WD'(DEPTH);
    endfunction

endpackage

// File: rtl/ram_sp_arb_192x128_if.sv
// Client and RAM-side signal bundle of the 192x128 RAM arbiter.
// Handshake: a client holds req/adr/msk/dat stable until gnt; each gnt consumes one access.
interface ram_sp_arb_192x128_if;
    import enc_mem_pkg::*;

    logic              wr_req_i;
    logic [ADR_WD-1:0] wr_adr_i;
    logic [DAT_WD-1:0] wr_msk_i;
    logic [DAT_WD-1:0] wr_dat_i;
    logic              wr_gnt_o;

    logic              rd0_req_i;
    logic [ADR_WD-1:0] rd0_adr_i;
    logic              rd0_gnt_o;
    logic              rd0_val_o;
    logic              rd1_req_i;
    logic [ADR_WD-1:0] rd1_adr_i;
    logic              rd1_gnt_o;
    logic              rd1_val_o;
    logic [DAT_WD-1:0] rd_dat_o;

    logic [ADR_WD-1:0] ram_adr_o;
    logic [DAT_WD-1:0] ram_wr_ena_o;
    logic [DAT_WD-1:0] ram_wr_dat_o;
    logic              ram_rd_ena_o;
    logic [DAT_WD-1:0] ram_rd_dat_i;

    modport slave (
        input  wr_req_i, wr_adr_i, wr_msk_i, wr_dat_i,
        input  rd0_req_i, rd0_adr_i, rd1_req_i, rd1_adr_i,
        input  ram_rd_dat_i,
        output wr_gnt_o, rd0_gnt_o, rd0_val_o, rd1_gnt_o, rd1_val_o, rd_dat_o,
        output ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o
    );

    modport master (
        output wr_req_i, wr_adr_i, wr_msk_i, wr_dat_i,
        output rd0_req_i, rd0_adr_i, rd1_req_i, rd1_adr_i,
        output ram_rd_dat_i,
        input  wr_gnt_o, rd0_gnt_o, rd0_val_o, rd1_gnt_o, rd1_val_o, rd_dat_o,
        input  ram_adr_o, ram_wr_ena_o, ram_wr_dat_o, ram_rd_ena_o
    );

endinterface

// File: rtl/ram_sp_arb_192x128_rr_arb3.sv
// Three-way round-robin picker: grants the first requester scanning cyclically
// from ptr, then moves ptr just past the winner.
module rr_arb3
    import enc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] ptr
);

    logic [1:0] ptr_nxt;
    logic [1:0] c0, c1, c2;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        case (p)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) ptr <= CLI_WR;
        else     ptr <= ptr_nxt;
    end

    always_comb begin
        gnt     = 3'b000;
        ptr_nxt = ptr;
        // ptr never holds 3, but map it to 0 so the scan stays in range
        c0 = (ptr == 2'd3) ? 2'd0 : ptr;
        c1 = nxt(c0);
        c2 = nxt(c1);
        if      (req[c0]) gnt[c0] = 1'b1;
        else if (req[c1]) gnt[c1] = 1'b1;
        else if (req[c2]) gnt[c2] = 1'b1;

        if      (gnt[CLI_WR])  ptr_nxt = CLI_RD0;
        else if (gnt[CLI_RD0]) ptr_nxt = CLI_RD1;
        else if (gnt[CLI_RD1]) ptr_nxt = CLI_WR;
    end

endmodule

// File: rtl/ram_sp_arb_192x128.sv
// Shares one 192x128 single-port bit-write-enable SRAM between a writer and two
// readers; drives the RAM from the grant and steers next-cycle read data back.
module ram_sp_arb_192x128
    import enc_mem_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    ram_sp_arb_192x128_if.slave         bus,
    output logic                        err_o,
    output logic [1:0]                  dbg_ptr
);

    logic [2:0] req;
    logic [2:0] gnt;
    logic       wr_ill, rd0_ill, rd1_ill;
    logic       acc_ill;
    rd_tag_t    tag, tag_nxt;

    // No grants while reset is held, so the RAM sees nothing during reset.
    assign req = rst ? 3'b000 : {bus.rd1_req_i, bus.rd0_req_i, bus.wr_req_i};

    rr_arb3 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt),
        .ptr (dbg_ptr)
    );

    assign bus.wr_gnt_o  = gnt[CLI_WR];
    assign bus.rd0_gnt_o = gnt[CLI_RD0];
    assign bus.rd1_gnt_o = gnt[CLI_RD1];

    assign wr_ill  = adr_ill(bus.wr_adr_i);
    assign rd0_ill = adr_ill(bus.rd0_adr_i);
    assign rd1_ill = adr_ill(bus.rd1_adr_i);

    always_comb begin
        bus.ram_adr_o    = '0;
        bus.ram_wr_ena_o = '0;
        bus.ram_wr_dat_o = '0;
        bus.ram_rd_ena_o = 1'b0;
        // Illegal addresses are still granted but kill the RAM strobe.
        if (gnt[CLI_WR]) begin
            bus.ram_adr_o    = bus.wr_adr_i;
            bus.ram_wr_dat_o = bus.wr_dat_i;
            bus.ram_wr_ena_o = wr_ill ? '0 : bus.wr_msk_i;
        end else if (gnt[CLI_RD0]) begin
            bus.ram_adr_o    = bus.rd0_adr_i;
            bus.ram_rd_ena_o = ~rd0_ill;
        end else if (gnt[CLI_RD1]) begin
            bus.ram_adr_o    = bus.rd1_adr_i;
            bus.ram_rd_ena_o = ~rd1_ill;
        end
    end

    always_comb begin
        tag_nxt.vld = gnt[CLI_RD0] | gnt[CLI_RD1];
        tag_nxt.id  = gnt[CLI_RD1];
        tag_nxt.ill = gnt[CLI_RD1] ? rd1_ill : rd0_ill;
    end

    assign acc_ill = (gnt[CLI_WR]  & wr_ill)
                   | (gnt[CLI_RD0] & rd0_ill)
                   | (gnt[CLI_RD1] & rd1_ill);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag   <= '0;
            err_o <= 1'b0;
        end else begin
            tag <= tag_nxt;
            if (acc_ill) err_o <= 1'b1;
        end
    end

    // A read pending across a reset edge is dropped, including in the reset cycle.
    assign bus.rd0_val_o = ~rst & tag.vld & ~tag.id;
    assign bus.rd1_val_o = ~rst & tag.vld &  tag.id;
    assign bus.rd_dat_o  = (~rst & tag.vld & ~tag.ill) ? bus.ram_rd_dat_i : '0;

endmodule

// File: tb/tb_ram_sp_arb_192x128.sv
// Randomized bench for ram_sp_arb_192x128 with a behavioural RAM and a
// cycle-level reference model of the arbitration and read-return rules.
module tb_ram_sp_arb_192x128;
  import enc_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  logic err_o;
  logic [1:0] dbg_ptr;
  always #5 clk = ~clk;

  ram_sp_arb_192x128_if bus ();

  ram_sp_arb_192x128 dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_o   (err_o),
    .dbg_ptr (dbg_ptr)
  );

  function automatic logic [DAT_WD-1:0] init_word(input int i);
    logic [31:0] u;
    u = i;
    return {u * 32'h9E3779B1, ~u * 32'h85EBCA6B, u ^ 32'hDEADBEEF, u * 32'd7 + 32'd1};
  endfunction

  // ---------------- behavioural RAM ----------------
  logic [DAT_WD-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
    end else if (int'(bus.ram_adr_o) < DEPTH) begin
      if (bus.ram_rd_ena_o) bus.ram_rd_dat_i <= ram_mem[bus.ram_adr_o];
      ram_mem[bus.ram_adr_o] <= (ram_mem[bus.ram_adr_o] & ~bus.ram_wr_ena_o)
                              | (bus.ram_wr_dat_o & bus.ram_wr_ena_o);
    end
  end

  // ---------------- client state (index 0 = W, 1 = R0, 2 = R1) ----------------
  logic              cli_req [3];
  logic [ADR_WD-1:0] cli_adr [3];
  logic [DAT_WD-1:0] cli_msk;
  logic [DAT_WD-1:0] cli_dat;

  // ---------------- reference model ----------------
  logic [DAT_WD-1:0] ref_mem [0:DEPTH-1];
  logic [DAT_WD-1:0] exp_q [$];
  int   m_ptr;
  bit   m_err;
  bit   m_pend;
  int   m_pid;
  int   m_win;
  int   obs_idx;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DAT_WD-1:0] got, input logic [DAT_WD-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    bus.wr_req_i  = cli_req[0];
    bus.wr_adr_i  = cli_adr[0];
    bus.wr_msk_i  = cli_msk;
    bus.wr_dat_i  = cli_dat;
    bus.rd0_req_i = cli_req[1];
    bus.rd0_adr_i = cli_adr[1];
    bus.rd1_req_i = cli_req[2];
    bus.rd1_adr_i = cli_adr[2];
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) cli_req[i] = 1'b0;
  endtask

  task automatic set_wr(input logic [ADR_WD-1:0] a, input logic [DAT_WD-1:0] m, input logic [DAT_WD-1:0] d);
    cli_req[0] = 1'b1; cli_adr[0] = a; cli_msk = m; cli_dat = d;
  endtask

  task automatic set_rd(input int r, input logic [ADR_WD-1:0] a);
    cli_req[r] = 1'b1; cli_adr[r] = a;
  endtask

  // One clock cycle: drive, check against the model at negedge, advance model.
  task automatic step();
    logic              e_v0, e_v1, ill;
    logic [DAT_WD-1:0] e_dat, e_wena, e_wdat, popped;
    logic [ADR_WD-1:0] e_adr;
    logic              e_rena;
    int                c;
    drive();
    @(negedge clk);
    e_v0 = 1'b0; e_v1 = 1'b0; e_dat = '0;
    if (m_pend) begin
      popped = exp_q.pop_front();
      if (!rst) begin
        e_v0 = (m_pid == 0);
        e_v1 = (m_pid == 1);
        e_dat = popped;
      end
    end
    m_win = -1;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        c = (m_ptr + k) % 3;
        if (m_win < 0 && cli_req[c]) m_win = c;
      end
    end
    e_adr = '0; e_wena = '0; e_wdat = '0; e_rena = 1'b0; ill = 1'b0;
    if (m_win >= 0) begin
      e_adr = cli_adr[m_win];
      ill = int'(cli_adr[m_win]) >= DEPTH;
      if (m_win == 0) begin
        e_wdat = cli_dat;
        e_wena = ill ? '0 : cli_msk;
      end else begin
        e_rena = !ill;
      end
    end
    obs_idx = bus.wr_gnt_o ? 0 : bus.rd0_gnt_o ? 1 : bus.rd1_gnt_o ? 2 : -1;
    chk("wr_gnt",  bus.wr_gnt_o,  m_win == 0);
    chk("rd0_gnt", bus.rd0_gnt_o, m_win == 1);
    chk("rd1_gnt", bus.rd1_gnt_o, m_win == 2);
    chk("rd0_val", bus.rd0_val_o, e_v0);
    chk("rd1_val", bus.rd1_val_o, e_v1);
    chk("rd_dat",  bus.rd_dat_o,  e_dat);
    chk("ram_adr", bus.ram_adr_o, e_adr);
    chk("ram_wena", bus.ram_wr_ena_o, e_wena);
    chk("ram_wdat", bus.ram_wr_dat_o, e_wdat);
    chk("ram_rena", bus.ram_rd_ena_o, e_rena);
    chk("err",     err_o, m_err);
    chk("ptr",     dbg_ptr, m_ptr[1:0]);
    // advance the model to the next cycle
    if (rst) begin
      m_ptr = 0; m_err = 0; m_pend = 0; exp_q.delete();
    end else begin
      m_pend = 0;
      if (m_win >= 0) begin
        m_ptr = (m_win + 1) % 3;
        if (ill) m_err = 1;
        if (m_win == 0) begin
          if (!ill) ref_mem[cli_adr[0]] = (ref_mem[cli_adr[0]] & ~cli_msk) | (cli_dat & cli_msk);
        end else begin
          m_pend = 1;
          m_pid = m_win - 1;
          exp_q.push_back(ill ? '0 : ref_mem[cli_adr[m_win]]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DAT_WD-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [ADR_WD-1:0] rnd_adr();
    if ($urandom_range(0, 49) == 0) return ADR_WD'($urandom_range(DEPTH, 255));
    return ADR_WD'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic new_req(input int i);
    int sel;
    cli_req[i] = 1'b1;
    cli_adr[i] = rnd_adr();
    if (i == 0) begin
      sel = $urandom_range(0, 3);
      cli_msk = (sel == 0) ? '1 : (sel == 1) ? '0 : rnd128();
      cli_dat = rnd128();
    end
  endtask

  // ---------------- main sequence ----------------
  int seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 3; i++) begin cli_req[i] = 1'b0; cli_adr[i] = '0; end
    cli_msk = '0; cli_dat = '0;
    bus.ram_rd_dat_i = '0;
    m_ptr = 0; m_err = 0; m_pend = 0; m_pid = 0; m_win = -1; obs_idx = -1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    ram_init = 1'b0;
    step();
    rst = 1'b0;

    // reset then idle
    repeat (5) step();

    // write then read-back of the same address in the next cycle
    set_wr(8'd10, '1, {16{8'hA5}});
    step();
    idle(); set_rd(1, 8'd10);
    step();
    idle();
    step();

    // all three continuously requesting from reset
    rst = 1'b1; step(); rst = 1'b0;
    set_wr(8'd1, '1, rnd128()); set_rd(1, 8'd2); set_rd(2, 8'd3);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("order", 128'(obs_idx), 128'(seq[i]));
    end
    idle();
    repeat (2) step();

    // partial write masks
    set_wr(8'd20, '1, '1);                   step();
    set_wr(8'd20, 128'hFF, 128'hFF);          step();
    set_wr(8'd20, 128'hFF00, '0);             step();
    idle(); set_rd(1, 8'd20);                 step();
    idle();                                   step();

    // illegal addresses
    set_rd(2, 8'd200);                        step();
    idle();                                   step();
    set_wr(8'd192, '1, '1);                   step();
    idle();
    repeat (2) step();

    // reset arriving one cycle after a read grant
    rst = 1'b1; step(); rst = 1'b0;
    set_rd(1, 8'd5);                          step();
    idle(); rst = 1'b1;                       step();
    rst = 1'b0;
    repeat (2) step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        if (!cli_req[i]) begin
          if ($urandom_range(0, 9) < 6) new_req(i);
        end else if (m_win == i) begin
          if ($urandom_range(0, 9) < 7) new_req(i);
          else cli_req[i] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          cli_req[i] = 1'b0;
        end
      end
      if (n == 300) begin
        idle(); rst = 1'b1; step(); rst = 1'b0;
      end
    end
    idle();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
